// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_e;

    // Consecutive WAIT_RD cycles without Rd_valid before a read is abandoned
    localparam int unsigned TIMEOUT = 7;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side and register-file-side signals of regfile_arbiter.
interface regfile_arbiter_if #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
);
    localparam int unsigned addr_w = $clog2(depth);

    // requester k is bit/element k
    logic [1:0]             req;
    logic [1:0]             wr;
    logic [1:0][addr_w-1:0] addr;
    logic [1:0][width-1:0]  wr_data;
    logic [1:0]             gnt;
    logic [1:0][width-1:0]  rd_data;
    logic [1:0]             rd_valid;
    logic [1:0]             err;

    // register-file side
    logic                   wr_en;
    logic                   rd_en;
    logic [addr_w-1:0]      a;
    logic [width-1:0]       rf_wr_data;
    logic [width-1:0]       rf_rd_data;
    logic                   rf_rd_valid;

    modport slave (
        input  req, wr, addr, wr_data, rf_rd_data, rf_rd_valid,
        output gnt, rd_data, rd_valid, err, wr_en, rd_en, a, rf_wr_data
    );

    modport master (
        output req, wr, addr, wr_data, rf_rd_data, rf_rd_valid,
        input  gnt, rd_data, rd_valid, err, wr_en, rd_en, a, rf_wr_data
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin selector; pointer remembers the last granted requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_idx,
    output logic [1:0] gnt_c
);
    logic last_q;

    // Reset to 1 so requester 0 wins the first contended round
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= upd_idx;
        end
    end

    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single register-file port with read timeout.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 16
) (
    input  logic              clk,
    input  logic              reset,
    regfile_arbiter_if.slave  bus
);
    localparam int unsigned addr_w = $clog2(depth);

    state_e                 state_q, state_d;
    logic                   win_q, win_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [1:0]             rdv_q, rdv_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][width-1:0]  rd_data_q, rd_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   rd_en_q, rd_en_d;
    logic [addr_w-1:0]      a_q, a_d;
    logic [width-1:0]       wd_q, wd_d;
    logic [1:0]             arb_gnt_c;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req),
        .update  (state_q == ISSUE),
        .upd_idx (win_q),
        .gnt_c   (arb_gnt_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            rdv_q     <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            a_q       <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            rdv_q     <= rdv_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            a_q       <= a_d;
            wd_q      <= wd_d;
        end
    end

    // Outputs are computed one cycle ahead so they appear registered in the target state
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        rdv_d     = '0;
        err_d     = '0;
        rd_data_d = rd_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        a_d       = a_q;
        wd_d      = wd_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win_d   = arb_gnt_c[1];
                    gnt_d   = arb_gnt_c;
                    wr_en_d = bus.wr[arb_gnt_c[1]];
                    rd_en_d = !bus.wr[arb_gnt_c[1]];
                    a_d     = bus.addr[arb_gnt_c[1]];
                    wd_d    = bus.wr_data[arb_gnt_c[1]];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = wr_en_q ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.rf_rd_valid) begin
                    rdv_d[win_q]     = 1'b1;
                    rd_data_d[win_q] = bus.rf_rd_data;
                    state_d          = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdv_d[win_q]     = 1'b1;
                    err_d[win_q]     = 1'b1;
                    rd_data_d[win_q] = '0;
                    state_d          = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt        = gnt_q;
    assign bus.rd_valid   = rdv_q;
    assign bus.err        = err_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.a          = a_q;
    assign bus.rf_wr_data = wd_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: transaction timeline model plus directed literal checks.
module tb_regfile_arbiter;
    localparam int unsigned W    = 8;
    localparam int unsigned D    = 16;
    localparam int unsigned AW   = $clog2(D);
    localparam int          MAXC = 4096;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    regfile_arbiter_if #(.width(W), .depth(D)) bus ();

    regfile_arbiter #(.width(W), .depth(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle index (cycle n = interval after posedge n)
    bit [1:0]    e_gnt  [MAXC];
    bit [1:0]    e_rdv  [MAXC];
    bit [1:0]    e_err  [MAXC];
    bit          e_wen  [MAXC];
    bit          e_ren  [MAXC];
    bit          e_rst  [MAXC];
    bit [AW-1:0] e_a    [MAXC];
    bit [W-1:0]  e_wd   [MAXC];
    bit [W-1:0]  e_rdat [MAXC];
    bit [W-1:0]  held   [2];
    int          last = 1;

    logic [1:0]    obs_gnt;
    logic          obs_wen, obs_ren;
    logic [AW-1:0] obs_a;
    logic [W-1:0]  obs_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (e_rst[cyc]) begin
                held[0] = '0;
                held[1] = '0;
                chk("rst_gnt",   32'(bus.gnt), 32'd0);
                chk("rst_rdv",   32'(bus.rd_valid), 32'd0);
                chk("rst_err",   32'(bus.err), 32'd0);
                chk("rst_en",    32'({bus.wr_en, bus.rd_en}), 32'd0);
                chk("rst_a",     32'(bus.a), 32'd0);
                chk("rst_wd",    32'(bus.rf_wr_data), 32'd0);
                chk("rst_rdat0", 32'(bus.rd_data[0]), 32'd0);
                chk("rst_rdat1", 32'(bus.rd_data[1]), 32'd0);
            end else begin
                if (e_rdv[cyc][0]) held[0] = e_rdat[cyc];
                if (e_rdv[cyc][1]) held[1] = e_rdat[cyc];
                chk("gnt",    32'(bus.gnt), 32'(e_gnt[cyc]));
                chk("rdv",    32'(bus.rd_valid), 32'(e_rdv[cyc]));
                chk("err",    32'(bus.err), 32'(e_err[cyc]));
                chk("wr_en",  32'(bus.wr_en), 32'(e_wen[cyc]));
                chk("rd_en",  32'(bus.rd_en), 32'(e_ren[cyc]));
                chk("excl_en", 32'(bus.wr_en & bus.rd_en), 32'd0);
                if (e_wen[cyc] || e_ren[cyc]) begin
                    chk("a",  32'(bus.a), 32'(e_a[cyc]));
                    chk("wd", 32'(bus.rf_wr_data), 32'(e_wd[cyc]));
                end
                chk("rdat0", 32'(bus.rd_data[0]), 32'(held[0]));
                chk("rdat1", 32'(bus.rd_data[1]), 32'(held[1]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic scribble();
        bus.req        = 2'($urandom);
        bus.wr         = 2'($urandom);
        bus.addr[0]    = AW'($urandom);
        bus.addr[1]    = AW'($urandom);
        bus.wr_data[0] = W'($urandom);
        bus.wr_data[1] = W'($urandom);
    endtask

    // Launch at current cycle k; d = read response delay in WAIT_RD cycles
    // (0..6 answered, >=7 times out, <0 times out and returns right after ISSUE).
    task automatic txn(input bit [1:0] mask, input bit [1:0] wr2,
                       input int unsigned a0, input int unsigned a1,
                       input int unsigned wd0, input int unsigned wd1,
                       input int d, input int unsigned rdat,
                       output int win, output int k);
        int p;
        k = cyc;
        bus.req        = mask;
        bus.wr         = wr2;
        bus.addr[0]    = AW'(a0);
        bus.addr[1]    = AW'(a1);
        bus.wr_data[0] = W'(wd0);
        bus.wr_data[1] = W'(wd1);
        win  = (mask == 2'b11) ? 1 - last : (mask[1] ? 1 : 0);
        last = win;
        e_gnt[k+1] = (win == 1) ? 2'b10 : 2'b01;
        e_wen[k+1] = wr2[win];
        e_ren[k+1] = !wr2[win];
        e_a[k+1]   = AW'((win == 1) ? a1 : a0);
        e_wd[k+1]  = W'((win == 1) ? wd1 : wd0);
        p = (d >= 0 && d <= 6) ? k + 3 + d : k + 9;
        if (!wr2[win]) begin
            e_rdv[p][win] = 1'b1;
            if (d >= 0 && d <= 6) begin
                e_rdat[p] = W'(rdat);
            end else begin
                e_err[p][win] = 1'b1;
                e_rdat[p]     = '0;
            end
        end
        step();
        obs_gnt = bus.gnt;
        obs_wen = bus.wr_en;
        obs_ren = bus.rd_en;
        obs_a   = bus.a;
        obs_wd  = bus.rf_wr_data;
        if (wr2[win]) begin
            bus.rf_rd_valid = 1'($urandom);
            step();
            bus.req = '0;
            return;
        end
        if (d < 0) begin
            bus.req         = '0;
            bus.rf_rd_valid = 1'b0;
            return;
        end
        scribble();
        bus.rf_rd_valid = 1'($urandom);
        while (cyc < p) begin
            step();
            if (cyc < p) scribble();
            else bus.req = '0;
            bus.rf_rd_data  = (cyc == k + 2 + d) ? W'(rdat) : W'($urandom);
            bus.rf_rd_valid = (cyc == k + 2 + d) || (cyc == p && $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        #(MAXC * 10 + 1000);
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int win, k, sel, d;
        reset           = 1'b1;
        bus.req         = '0;
        bus.wr          = '0;
        bus.addr        = '0;
        bus.wr_data     = '0;
        bus.rf_rd_data  = '0;
        bus.rf_rd_valid = 1'b0;
        e_rst[1] = 1'b1;
        e_rst[2] = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Both write together: 0 first, then 1 on the next round
        txn(2'b11, 2'b11, 1, 2, 8'h11, 8'h22, 0, 0, win, k);
        chk("dual_r1_gnt", 32'(obs_gnt), 32'h1);
        chk("dual_r1_a",   32'(obs_a), 32'd1);
        txn(2'b10, 2'b10, 1, 2, 8'h11, 8'h22, 0, 0, win, k);
        chk("dual_r2_gnt", 32'(obs_gnt), 32'h2);
        chk("dual_r2_a",   32'(obs_a), 32'd2);

        // Single write from requester 0
        txn(2'b01, 2'b01, 3, 0, 8'hA5, 0, 0, 0, win, k);
        chk("wr_gnt", 32'(obs_gnt), 32'h1);
        chk("wr_en",  32'(obs_wen), 32'd1);
        chk("wr_a",   32'(obs_a), 32'd3);
        chk("wr_wd",  32'(obs_wd), 32'hA5);
        chk("wr_idle_gnt", 32'(bus.gnt), 32'd0);
        chk("wr_idle_en",  32'(bus.wr_en), 32'd0);

        // Read from requester 1 answered one cycle after RdEN
        txn(2'b10, 2'b00, 0, 5, 0, 0, 0, 8'h3C, win, k);
        chk("rd_ren",   32'(obs_ren), 32'd1);
        chk("rd_a",     32'(obs_a), 32'd5);
        chk("rd_rdv",   32'(bus.rd_valid), 32'h2);
        chk("rd_rdat1", 32'(bus.rd_data[1]), 32'h3C);
        chk("rd_err",   32'(bus.err), 32'd0);

        // Read never answered: seven silent WAIT_RD cycles, then timeout
        txn(2'b01, 2'b00, 4, 0, 0, 0, -1, 0, win, k);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_wait_err", 32'(bus.err), 32'd0);
            chk("to_wait_rdv", 32'(bus.rd_valid), 32'd0);
        end
        step();
        chk("to_err",   32'(bus.err), 32'h1);
        chk("to_rdv",   32'(bus.rd_valid), 32'h1);
        chk("to_rdat0", 32'(bus.rd_data[0]), 32'd0);

        // Reset during WAIT_RD, then a late Rd_valid
        txn(2'b01, 2'b00, 6, 0, 0, 0, -1, 0, win, k);
        step();
        step();
        reset = 1'b1;
        e_rst[cyc+1] = 1'b1;
        e_rdv[k+9]   = '0;
        e_err[k+9]   = '0;
        last = 1;
        step();
        reset           = 1'b0;
        bus.rf_rd_valid = 1'b1;
        bus.rf_rd_data  = 8'h77;
        step();
        chk("late_rdv", 32'(bus.rd_valid), 32'd0);
        chk("late_err", 32'(bus.err), 32'd0);
        step();
        bus.rf_rd_valid = 1'b0;
        chk("late_rdv2",  32'(bus.rd_valid), 32'd0);
        chk("late_rdat0", 32'(bus.rd_data[0]), 32'd0);

        // Both hold Req for six rounds: grants alternate starting with 0
        for (int r = 0; r < 6; r++) begin
            txn(2'b11, 2'b11, $urandom, $urandom, $urandom, $urandom, 0, 0, win, k);
            chk("rr_alt", 32'(obs_gnt), (r % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Randomized traffic
        for (int it = 0; it < 250 && cyc < MAXC - 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                bus.req         = '0;
                bus.rf_rd_valid = 1'($urandom);
                step();
            end else if (sel == 1) begin
                bus.req         = '0;
                reset           = 1'b1;
                e_rst[cyc+1]    = 1'b1;
                last            = 1;
                step();
                reset = 1'b0;
            end else begin
                d = $urandom_range(0, 8);
                if (d == 8) d = 20;
                txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom,
                    $urandom, $urandom, d, $urandom, win, k);
            end
        end
        bus.req = '0;
        bus.rf_rd_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning register data width.
REQ-002 The block SHALL have parameter depth, default 16, meaning register count; address width is $clog2(depth).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high: CLK input 1, the single clock; Reset input 1, synchronous active-high reset.
REQ-004 Requester k (k = 0, 1) SHALL have these ports:
- Req_k input 1: access request.
- Wr_k input 1: 1 = write, 0 = read.
- Addr_k input $clog2(depth): register address.
- WrData_k input width: write data.
- Gnt_k output 1: one-cycle grant pulse.
- RdData_k output width: read data returned to requester k.
- RdValid_k output 1: one-cycle read-return pulse.
- Err_k output 1: one-cycle read-timeout pulse.
REQ-005 The register-file-side ports SHALL be:
- WrEN output 1: write enable.
- RdEN output 1: read enable.
- A output $clog2(depth): address.
- WrData output width: write data.
- RdData input width: read data.
- Rd_valid input 1: read data valid.

Function
REQ-006 The block SHALL implement FSM states IDLE, ISSUE and WAIT_RD.
REQ-007 In IDLE, when at least one Req_k is high at a clock edge, the block SHALL:
- select the winner;
- register its Wr, Addr and WrData;
- enter ISSUE.
REQ-008 In ISSUE, for exactly one cycle, the block SHALL drive:
- Gnt_winner = 1;
- A and WrData from the registered copy;
- WrEN = registered Wr, RdEN = !registered Wr.
REQ-009 From ISSUE, a write SHALL return to IDLE and a read SHALL enter WAIT_RD.
REQ-010 In WAIT_RD, when Rd_valid = 1, the block SHALL, in the next cycle:
- drive RdData_winner = the captured RdData;
- pulse RdValid_winner for one cycle;
- return to IDLE.
REQ-011 In WAIT_RD, if Rd_valid stays low for TIMEOUT = 7 consecutive cycles, the block SHALL:
- pulse Err_winner and RdValid_winner together;
- drive RdData_winner = 0;
- return to IDLE.
REQ-012 Arbitration SHALL be round-robin:
- When both requests are high, the requester not granted last wins.
- When only one request is high, that requester wins.
- The last-granted pointer updates in ISSUE.
REQ-013 Req_k, Wr_k, Addr_k and WrData_k SHALL be sampled only in IDLE; changes during ISSUE or WAIT_RD are ignored.
REQ-014 A requester SHALL deassert Req_k in the cycle after Gnt_k. A Req_k still high when the FSM is back in IDLE is a new request.
REQ-015 Rd_valid asserted outside WAIT_RD SHALL be ignored.
REQ-016 WrEN, RdEN, Gnt_k, RdValid_k and Err_k SHALL be mutually consistent:
- Gnt_k, RdValid_k and Err_k are at most one-hot across k.
- WrEN and RdEN are never both high.
REQ-017 Throughput SHALL be one write per 2 cycles; a read takes 3 cycles minimum from request sample to RdValid.
REQ-018 The non-winning requester SHALL see Gnt = 0, RdValid = 0 and Err = 0 throughout.
REQ-019 RdData_k SHALL hold its last value between RdValid_k pulses.

Reset
REQ-020 While Reset = 1 at a clock edge, the block SHALL set:
- state = IDLE;
- all Gnt_k, RdValid_k, Err_k, WrEN and RdEN = 0;
- A = 0, WrData = 0, RdData_k = 0;
- timeout counter = 0;
- last-granted pointer = 1, so requester 0 wins first.
REQ-021 Reset asserted mid-read SHALL abandon the access with no RdValid or Err pulse; a late Rd_valid after reset SHALL be ignored.

Structure
REQ-022 The state encoding and the TIMEOUT constant SHALL be defined in a shared package regfile_arb_pkg.
REQ-023 The round-robin selection and pointer SHALL be one sub-module, rr_arb2 (2-input request, 1-bit pointer, one-hot grant).
REQ-024 All outputs SHALL be registered.

Verification
REQ-025 Reset, then Req0 write Addr0=3, WrData0=8'hA5 -> one cycle with WrEN=1, A=3, WrData=8'hA5 and Gnt0=1; back in IDLE next cycle.
REQ-026 Both requesters write simultaneously (Addr0=1, Addr1=2) -> requester 0 is granted first; requester 1 is granted on the following arbitration round.
REQ-027 Req1 read Addr1=5, model returns Rd_valid one cycle after RdEN with RdData=8'h3C -> RdValid1=1 with RdData1=8'h3C; RdValid0 stays 0.
REQ-028 Read with Rd_valid never asserted -> exactly 7 WAIT_RD cycles, then Err0=1, RdValid0=1 and RdData0=0, then IDLE.
REQ-029 Reset asserted during WAIT_RD, then Rd_valid pulsed -> no RdValid or Err; all outputs at reset values.
REQ-030 Both requesters hold Req continuously for 6 rounds -> grants alternate 0,1,0,1,0,1; WrEN and RdEN never both high.
